// File: rtl/dll_lcrc_inserter_if.sv
// Beat bus between the DLL packetizer, the LCRC inserter and the retry buffer.
// master drives data_i..stp_num_i and sinks the *_o side; slave is the inserter.
interface dll_lcrc_inserter_if #(
    parameter int PIPE_DATA_WIDTH = 256
);
    localparam int LW = PIPE_DATA_WIDTH / 8;

    logic [7:0][LW-1:0] data_i;
    logic               wren_i;
    logic               lcrc_i;
    logic [2:0]         stp_idx_i;
    logic [1:0]         stp_num_i;

    logic [7:0][LW-1:0] data_o;
    logic               wren_o;
    logic [2:0]         stp_idx_o;
    logic [1:0]         stp_num_o;
    logic [2:0]         lcrc_idx_o;
    logic               tlp_done_o;
    logic [11:0]        done_seq_o;
    logic               err_o;

    modport master (
        output data_i, wren_i, lcrc_i, stp_idx_i, stp_num_i,
        input  data_o, wren_o, stp_idx_o, stp_num_o,
        input  lcrc_idx_o, tlp_done_o, done_seq_o, err_o
    );

    modport slave (
        input  data_i, wren_i, lcrc_i, stp_idx_i, stp_num_i,
        output data_o, wren_o, stp_idx_o, stp_num_o,
        output lcrc_idx_o, tlp_done_o, done_seq_o, err_o
    );
endinterface

// File: rtl/dll_lcrc_inserter.sv
// LCRC inserter: folds seq + TLP dwords into a reflected CRC-32 and overwrites
// the FFFF_FFFF slot dword. Ports: sclk, srst_n, bus (slave); 1-cycle latency.
module dll_lcrc_inserter #(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int LEN_BITS        = 11
) (
    input  logic                   sclk,
    input  logic                   srst_n,
    dll_lcrc_inserter_if.slave     bus
);
    localparam int LW = PIPE_DATA_WIDTH / 8;
    localparam logic [31:0] POLY = 32'hEDB8_8320;
    localparam logic [31:0] SLOT = 32'hFFFF_FFFF;

    typedef enum logic {S_IDLE, S_TLP} state_t;

    state_t              state;
    logic [31:0]         crc;
    logic [LEN_BITS-1:0] rem;
    logic [11:0]         seq;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
        return x;
    endfunction

    // Reflected CRC consumes the dword LSB first, i.e. bytes [7:0] upward.
    function automatic logic [31:0] crc_dw(
        input logic [31:0] c,
        input logic [31:0] d
    );
        logic [31:0] x;
        x = c ^ d;
        for (int k = 0; k < 32; k++)
            x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
        return x;
    endfunction

    logic [11:0]         stp_seq;
    logic [LEN_BITS-1:0] stp_len;
    logic                has_stp;
    logic                len_ok;

    logic [7:0][LW-1:0]  d_n;
    logic [31:0]         c_n;
    logic [LEN_BITS-1:0] r_n;
    logic [11:0]         s_n;
    logic [3:0]          base;
    logic                hit;
    logic [2:0]          idx;
    logic                e;

    assign stp_seq = bus.data_i[bus.stp_idx_i][27:16];
    assign stp_len = bus.data_i[bus.stp_idx_i][4 +: LEN_BITS];
    assign has_stp = (bus.stp_num_i == 2'd1);
    // Smallest TLP is STP + 3DW header + LCRC.
    assign len_ok  = (stp_len >= LEN_BITS'(5));

    always_comb begin
        d_n  = bus.data_i;
        c_n  = crc;
        r_n  = rem;
        s_n  = seq;
        base = 4'd0;
        hit  = 1'b0;
        idx  = 3'd0;
        e    = 1'b0;

        if (bus.stp_num_i > 2'd1)
            e = 1'b1;
        if (has_stp && state == S_TLP)
            e = 1'b1;
        if (has_stp && !len_ok) begin
            e   = 1'b1;
            r_n = '0;
        end
        if (has_stp && len_ok) begin
            c_n  = crc_byte(crc_byte(32'hFFFF_FFFF, {4'h0, stp_seq[11:8]}),
                            stp_seq[7:0]);
            r_n  = stp_len - LEN_BITS'(1);
            s_n  = stp_seq;
            base = {1'b0, bus.stp_idx_i} + 4'd1;
        end

        // rem==0 marks "outside a TLP", so lanes past the slot pass through.
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= base && r_n != '0) begin
                if (r_n > LEN_BITS'(1)) begin
                    c_n = crc_dw(c_n, bus.data_i[i]);
                    r_n = r_n - LEN_BITS'(1);
                end else begin
                    d_n[i] = ~c_n;
                    hit    = 1'b1;
                    idx    = 3'(i);
                    r_n    = '0;
                    if (!bus.lcrc_i || bus.data_i[i] != SLOT)
                        e = 1'b1;
                end
            end
        end

        if (bus.lcrc_i && !hit)
            e = 1'b1;
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state          <= S_IDLE;
            crc            <= 32'hFFFF_FFFF;
            rem            <= '0;
            seq            <= '0;
            bus.data_o     <= '0;
            bus.wren_o     <= 1'b0;
            bus.stp_idx_o  <= '0;
            bus.stp_num_o  <= '0;
            bus.lcrc_idx_o <= '0;
            bus.tlp_done_o <= 1'b0;
            bus.done_seq_o <= '0;
            bus.err_o      <= 1'b0;
        end else begin
            bus.stp_idx_o <= bus.stp_idx_i;
            bus.stp_num_o <= bus.stp_num_i;
            if (bus.wren_i) begin
                state          <= (r_n != '0) ? S_TLP : S_IDLE;
                crc            <= c_n;
                rem            <= r_n;
                seq            <= s_n;
                bus.data_o     <= d_n;
                bus.wren_o     <= 1'b1;
                bus.lcrc_idx_o <= idx;
                bus.tlp_done_o <= hit;
                bus.done_seq_o <= hit ? s_n : 12'h0;
                bus.err_o      <= e;
            end else begin
                bus.data_o     <= '0;
                bus.wren_o     <= 1'b0;
                bus.lcrc_idx_o <= '0;
                bus.tlp_done_o <= 1'b0;
                bus.done_seq_o <= '0;
                bus.err_o      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dll_lcrc_inserter.sv
// Bench for dll_lcrc_inserter: table of beats with expected outputs,
// plus hand-written reset sequences.
module tb_dll_lcrc_inserter;
    logic sclk = 1'b0;
    logic srst_n = 1'b0;
    always #5 sclk = ~sclk;

    dll_lcrc_inserter_if #(.PIPE_DATA_WIDTH(256)) bus ();

    dll_lcrc_inserter #(.PIPE_DATA_WIDTH(256), .LEN_BITS(11)) dut (
        .sclk   (sclk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    typedef logic [7:0][31:0] beat_t;

    typedef struct {
        beat_t       d;
        logic        wr;
        logic        lc;
        logic [2:0]  si;
        logic [1:0]  sn;
        beat_t       ed;
        logic        edone;
        logic        eerr;
        logic [2:0]  eidx;
        logic [11:0] eseq;
    } vec_t;

    vec_t tv[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] stp(input logic [11:0] sq,
                                        input logic [10:0] ln);
        return {4'hF, sq, 1'b0, ln, 4'hF};
    endfunction

    function automatic logic [31:0] mbyte(input logic [31:0] c,
                                          input logic [7:0] b);
        logic [31:0] x;
        x = c;
        for (int k = 0; k < 8; k++) begin
            if ((x[0] ^ b[k]) == 1'b1) x = (x >> 1) ^ 32'hEDB8_8320;
            else x = x >> 1;
        end
        return x;
    endfunction

    function automatic logic [31:0] model_lcrc(input logic [11:0] sq,
                                               input logic [31:0] h[8],
                                               input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        c = mbyte(c, {4'h0, sq[11:8]});
        c = mbyte(c, sq[7:0]);
        for (int j = 0; j < n; j++) begin
            c = mbyte(c, h[j][7:0]);
            c = mbyte(c, h[j][15:8]);
            c = mbyte(c, h[j][23:16]);
            c = mbyte(c, h[j][31:24]);
        end
        return ~c;
    endfunction

    function automatic void add(input beat_t d, input logic wr,
                                input logic lc, input logic [2:0] si,
                                input logic [1:0] sn, input beat_t ed,
                                input logic edone, input logic eerr,
                                input logic [2:0] eidx,
                                input logic [11:0] eseq);
        vec_t v;
        v.d = d; v.wr = wr; v.lc = lc; v.si = si; v.sn = sn;
        v.ed = ed; v.edone = edone; v.eerr = eerr;
        v.eidx = eidx; v.eseq = eseq;
        tv.push_back(v);
    endfunction

    task automatic drive(input beat_t d, input logic wr, input logic lc,
                         input logic [2:0] si, input logic [1:0] sn);
        bus.data_i    = d;
        bus.wren_i    = wr;
        bus.lcrc_i    = lc;
        bus.stp_idx_i = si;
        bus.stp_num_i = sn;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wren"}, 256'(bus.wren_o), 256'(0));
        chk({tag, "_data"}, bus.data_o, 256'(0));
        chk({tag, "_done"}, 256'(bus.tlp_done_o), 256'(0));
        chk({tag, "_err"},  256'(bus.err_o), 256'(0));
        chk({tag, "_seq"},  256'(bus.done_seq_o), 256'(0));
        chk({tag, "_idx"},  256'(bus.lcrc_idx_o), 256'(0));
    endtask

    initial begin
        beat_t b, e, z;
        logic [31:0] h1[8], h2[8], h3[8], h4[8];
        logic [31:0] l1, l2, l3, l4, l5;

        z = '0;
        h1 = '{32'h0400_0001, 32'h0000_000F, 32'h1234_5678,
               0, 0, 0, 0, 0};
        h2 = '{32'h6000_0004, 32'hABCD_00FF, 32'h0000_0010,
               32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444,
               32'h5555_6666, 32'h7777_8888};
        h3 = '{32'h4A00_0001, 32'h0100_0004, 32'hCAFE_0000,
               0, 0, 0, 0, 0};
        h4 = '{32'h0000_0001, 32'h8000_0000, 32'h0F0F_F0F0,
               0, 0, 0, 0, 0};
        l1 = model_lcrc(12'h000, h1, 3);
        l2 = model_lcrc(12'hFFF, h2, 8);
        l3 = model_lcrc(12'h000, h3, 3);
        l4 = model_lcrc(12'h007, h3, 3);
        l5 = model_lcrc(12'h123, h4, 3);

        // 3DW header, no payload, seq 0
        b = z; b[4] = stp(12'h000, 11'd5);
        b[5] = h1[0]; b[6] = h1[1]; b[7] = h1[2];
        add(b, 1, 0, 3'd4, 2'd1, b, 0, 0, 0, 0);
        b = z; b[0] = 32'hFFFF_FFFF; e = b; e[0] = l1;
        add(b, 1, 1, 3'd0, 2'd0, e, 1, 0, 3'd0, 12'h000);

        // 4DW header + 4DW payload, seq FFF
        b = z; b[3] = stp(12'hFFF, 11'd10);
        for (int j = 0; j < 4; j++) b[4+j] = h2[j];
        add(b, 1, 0, 3'd3, 2'd1, b, 0, 0, 0, 0);
        b = z; for (int j = 0; j < 4; j++) b[j] = h2[4+j];
        b[4] = 32'hFFFF_FFFF; e = b; e[4] = l2;
        add(b, 1, 1, 3'd0, 2'd0, e, 1, 0, 3'd4, 12'hFFF);

        // next TLP after wrap uses seq 0
        b = z; b[4] = stp(12'h000, 11'd5);
        b[5] = h3[0]; b[6] = h3[1]; b[7] = h3[2];
        add(b, 1, 0, 3'd4, 2'd1, b, 0, 0, 0, 0);
        b = z; b[0] = 32'hFFFF_FFFF; e = b; e[0] = l3;
        add(b, 1, 1, 3'd0, 2'd0, e, 1, 0, 3'd0, 12'h000);

        // same as first TLP with three bubbles before the LCRC beat
        b = z; b[4] = stp(12'h000, 11'd5);
        b[5] = h1[0]; b[6] = h1[1]; b[7] = h1[2];
        add(b, 1, 0, 3'd4, 2'd1, b, 0, 0, 0, 0);
        b = z; b[0] = 32'h5A5A_5A5A;
        for (int j = 0; j < 3; j++)
            add(b, 0, 1, 3'd0, 2'd0, z, 0, 0, 0, 0);
        b = z; b[0] = 32'hFFFF_FFFF; e = b; e[0] = l1;
        add(b, 1, 1, 3'd0, 2'd0, e, 1, 0, 3'd0, 12'h000);

        // missing lcrc_i on the LCRC beat
        b = z; b[4] = stp(12'h000, 11'd5);
        b[5] = h1[0]; b[6] = h1[1]; b[7] = h1[2];
        add(b, 1, 0, 3'd4, 2'd1, b, 0, 0, 0, 0);
        b = z; b[0] = 32'hFFFF_FFFF; e = b; e[0] = l1;
        add(b, 1, 0, 3'd0, 2'd0, e, 1, 1, 3'd0, 12'h000);

        // new STP while a TLP is open: first is abandoned
        b = z; b[3] = stp(12'h005, 11'd10);
        for (int j = 0; j < 4; j++) b[4+j] = h2[j];
        add(b, 1, 0, 3'd3, 2'd1, b, 0, 0, 0, 0);
        b = z; b[0] = h2[4]; b[1] = h2[5];
        b[4] = stp(12'h007, 11'd5);
        b[5] = h3[0]; b[6] = h3[1]; b[7] = h3[2];
        add(b, 1, 0, 3'd4, 2'd1, b, 0, 1, 0, 0);
        b = z; b[0] = 32'hFFFF_FFFF; e = b; e[0] = l4;
        add(b, 1, 1, 3'd0, 2'd0, e, 1, 0, 3'd0, 12'h007);

        // whole TLP inside one beat, then a plain beat
        b = z; b[0] = stp(12'h123, 11'd5);
        b[1] = h4[0]; b[2] = h4[1]; b[3] = h4[2];
        b[4] = 32'hFFFF_FFFF; b[5] = 32'h0000_00AA;
        e = b; e[4] = l5;
        add(b, 1, 1, 3'd0, 2'd1, e, 1, 0, 3'd4, 12'h123);
        b = z; b[2] = 32'h1357_9BDF;
        add(b, 1, 0, 3'd0, 2'd0, b, 0, 0, 0, 0);

        // bad slot contents: still inserted, error flagged
        b = z; b[0] = stp(12'h123, 11'd5);
        b[1] = h4[0]; b[2] = h4[1]; b[3] = h4[2];
        b[4] = 32'h0000_0000;
        e = b; e[4] = l5;
        add(b, 1, 1, 3'd0, 2'd1, e, 1, 1, 3'd4, 12'h123);

        // framing errors with no TLP open
        b = z; b[0] = stp(12'h001, 11'd5); b[4] = stp(12'h002, 11'd5);
        add(b, 1, 0, 3'd0, 2'd2, b, 0, 1, 0, 0);
        b = z; b[2] = stp(12'h003, 11'd4); b[6] = 32'hFFFF_FFFF;
        add(b, 1, 1, 3'd2, 2'd1, b, 0, 1, 0, 0);
        b = z; b[1] = 32'hFFFF_FFFF;
        add(b, 1, 1, 3'd0, 2'd0, b, 0, 1, 0, 0);
        b = z; b[3] = 32'h2468_ACE0;
        add(b, 1, 0, 3'd0, 2'd0, b, 0, 0, 0, 0);

        // reset state
        drive(z, 0, 0, 0, 0);
        repeat (2) @(posedge sclk);
        #1 chk_zero("rst");

        // asynchronous reset mid-TLP
        @(negedge sclk) srst_n = 1'b1;
        b = z; b[3] = stp(12'h0AB, 11'd10);
        for (int j = 0; j < 4; j++) b[4+j] = h2[j];
        drive(b, 1, 0, 3'd3, 2'd1);
        @(posedge sclk); #1;
        chk("pre_rst_wren", 256'(bus.wren_o), 256'(1));
        chk("pre_rst_data", bus.data_o, b);
        #1 srst_n = 1'b0;
        #1 chk_zero("async_rst");
        drive(z, 0, 0, 0, 0);
        @(negedge sclk) srst_n = 1'b1;
        repeat (2) begin
            @(posedge sclk); #1;
            chk("idle_wren", 256'(bus.wren_o), 256'(0));
        end

        foreach (tv[k]) begin
            @(negedge sclk);
            drive(tv[k].d, tv[k].wr, tv[k].lc, tv[k].si, tv[k].sn);
            @(posedge sclk); #1;
            chk($sformatf("v%0d_wren", k), 256'(bus.wren_o), 256'(tv[k].wr));
            chk($sformatf("v%0d_data", k), bus.data_o, tv[k].ed);
            chk($sformatf("v%0d_done", k), 256'(bus.tlp_done_o),
                256'(tv[k].edone));
            chk($sformatf("v%0d_err", k), 256'(bus.err_o), 256'(tv[k].eerr));
            if (tv[k].wr) begin
                chk($sformatf("v%0d_sidx", k), 256'(bus.stp_idx_o),
                    256'(tv[k].si));
                chk($sformatf("v%0d_snum", k), 256'(bus.stp_num_o),
                    256'(tv[k].sn));
            end
            if (tv[k].edone) begin
                chk($sformatf("v%0d_lidx", k), 256'(bus.lcrc_idx_o),
                    256'(tv[k].eidx));
                chk($sformatf("v%0d_seq", k), 256'(bus.done_seq_o),
                    256'(tv[k].eseq));
            end
        end

        @(negedge sclk) drive(z, 0, 0, 0, 0);
        @(posedge sclk); #1 chk_zero("tail");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
